fetch_unit: RTL and testbench

- Instruction-fetch client of the shared memory arbiter.
- Issues read-only requests through one arbiter client slot: request, addr, we, data_out, ready.
- Buffers fetched bytes in a small prefetch FIFO, tagged with their PC, and presents them to the decode/exec stage.
- Handles control-flow redirects by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Memory-arbiter client port used by the instruction fetch unit.
// master: the fetch unit (requester); slave: the arbiter side.
interface fetch_unit_if #(
  parameter int M_WIDTH = 8
);
  logic               mem_req;
  logic [M_WIDTH-1:0] mem_addr;
  logic               mem_we;
  logic [M_WIDTH-1:0] mem_data_out;
  logic               mem_ready;
  logic [M_WIDTH-1:0] mem_data_in;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_we,
    output mem_data_out,
    input  mem_ready,
    input  mem_data_in
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_we,
    input  mem_data_out,
    output mem_ready,
    output mem_data_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: read-only client of the shared memory arbiter.
// Fetches one byte at a time into a small PC-tagged prefetch FIFO and
// presents the head entry to decode. A redirect flushes the FIFO and
// drops the response of any fetch that is still in flight.
// Optional: define FETCH_DISCARD_CNT_EN to add a saturating 8-bit
// discard_cnt output counting responses dropped because of redirects.
module fetch_unit #(
  parameter int M_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       mem,
  output logic [M_WIDTH-1:0] instr,
  output logic [M_WIDTH-1:0] instr_pc,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               redirect,
  input  logic [M_WIDTH-1:0] redirect_pc
`ifdef FETCH_DISCARD_CNT_EN
  ,
  output logic [7:0]         discard_cnt
`endif
);

  // DEPTH is a power of two, so the pointers wrap for free.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  state_t             state_reg, state_next;
  logic [M_WIDTH-1:0] addr_reg, addr_next;
  logic [M_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic               discard_reg, discard_next;
  logic               push;
  logic               pop;

  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [M_WIDTH-1:0] data_mem [DEPTH];
  logic [M_WIDTH-1:0] pc_mem   [DEPTH];

  // Next-state logic for the request handshake, fetch PC and discard flag.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    fetch_pc_next = fetch_pc_reg;
    discard_next  = discard_reg;
    push          = 1'b0;
    case (state_reg)
      IDLE: begin
        // Only one fetch is ever in flight, so room now means room at push.
        if (!redirect && (count_reg < FULL)) begin
          state_next = REQ;
          addr_next  = fetch_pc_reg;
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          state_next = RELEASE;
          if (!discard_reg && !redirect) begin
            push          = 1'b1;
            fetch_pc_next = addr_reg + M_WIDTH'(1);
          end else begin
            discard_next = 1'b0;
          end
        end else if (redirect) begin
          // The request cannot be withdrawn; remember to drop its reply.
          discard_next = 1'b1;
        end
      end
      RELEASE: begin
        // The arbiter holds ready until it sees our request drop.
        if (!mem.mem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_next = redirect_pc;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      fetch_pc_reg <= '0;
      discard_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      fetch_pc_reg <= fetch_pc_next;
      discard_reg  <= discard_next;
    end
  end

  // A redirect wins over a same-cycle acknowledge.
  assign pop = instr_ack && (count_reg != '0) && !redirect;

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: fetched byte and the address it came from.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= mem.mem_data_in;
      pc_mem[wr_ptr_reg]   <= addr_reg;
    end
  end

  assign instr       = data_mem[rd_ptr_reg];
  assign instr_pc    = pc_mem[rd_ptr_reg];
  assign instr_valid = (count_reg != '0);

  assign mem.mem_req      = (state_reg == REQ);
  assign mem.mem_addr     = addr_reg;
  assign mem.mem_we       = 1'b0;
  assign mem.mem_data_out = '0;

`ifdef FETCH_DISCARD_CNT_EN
  logic       drop;
  logic [7:0] discard_cnt_reg;

  // A response is dropped when it lands while flagged or under a redirect.
  assign drop = (state_reg == REQ) && mem.mem_ready && (discard_reg || redirect);

  // Saturating count of dropped responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      discard_cnt_reg <= 8'd0;
    end else if (drop && (discard_cnt_reg != 8'hFF)) begin
      discard_cnt_reg <= discard_cnt_reg + 8'd1;
    end
  end

  assign discard_cnt = discard_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: arbiter model, reference model with
// an expected-instruction queue, and a monitor comparing DUT output.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_ack;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
`ifdef FETCH_DISCARD_CNT_EN
  logic [7:0] discard_cnt;
`endif

  fetch_unit_if #(.M_WIDTH(8)) bus ();

  fetch_unit #(.M_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (bus),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ack  (instr_ack),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
`ifdef FETCH_DISCARD_CNT_EN
    ,
    .discard_cnt(discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] mem_img [256];
  ent_t       exp_q [$];
  ent_t       log_q [$];
  int         ack_mode = 0;
  int         arb_fixed = -1;
  int         n_grants = 0;
  logic [7:0] last_grant_addr = 8'h00;
  bit         armed = 1'b0;
  bit         last_rst = 1'b0;
  logic [7:0] exp_pc = 8'h00;
  bit         m_discard = 1'b0;
  int         drop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Arbiter model: grants after 0..3 cycles, holds ready until req drops.
  initial begin : arbiter
    int a_state = 0;
    int a_cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_data_in = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (rst !== 1'b0) begin
        bus.mem_ready = 1'b0;
        a_state = 0;
      end else begin
        case (a_state)
          0: if (bus.mem_req === 1'b1) begin
               a_cnt = (arb_fixed >= 0) ? arb_fixed : int'($urandom_range(0, 3));
               if (a_cnt == 0) begin
                 bus.mem_ready = 1'b1;
                 bus.mem_data_in = mem_img[bus.mem_addr];
                 a_state = 2;
               end else a_state = 1;
             end
          1: begin
               a_cnt--;
               if (a_cnt == 0) begin
                 bus.mem_ready = 1'b1;
                 bus.mem_data_in = mem_img[bus.mem_addr];
                 a_state = 2;
               end
             end
          default: if (bus.mem_req !== 1'b1) begin
               bus.mem_ready = 1'b0;
               bus.mem_data_in = 8'($urandom);
               a_state = 0;
             end
        endcase
      end
    end
  end

  // Reference model: sequential PC stream, flushed and re-based by redirects.
  initial begin : model
    logic s_rst, s_redir, s_req, s_ready;
    logic [7:0] s_rpc, s_addr;
    bit grant;
    ent_t e;
    forever begin
      @(negedge clk);
      s_rst = rst; s_redir = redirect; s_rpc = redirect_pc;
      s_req = bus.mem_req; s_ready = bus.mem_ready; s_addr = bus.mem_addr;
      @(posedge clk);
      if (s_rst === 1'b1) begin
        exp_q.delete(); exp_pc = 8'h00; m_discard = 1'b0; drop_cnt = 0;
        armed = 1'b1; last_rst = 1'b1;
      end else if (armed) begin
        last_rst = 1'b0;
        grant = (s_req === 1'b1) && (s_ready === 1'b1);
        if (s_redir === 1'b1) begin
          exp_q.delete();
          exp_pc = s_rpc;
          if (grant) begin
            m_discard = 1'b0;
            if (drop_cnt < 255) drop_cnt++;
          end else if (s_req === 1'b1) m_discard = 1'b1;
        end else if (grant) begin
          if (m_discard) begin
            m_discard = 1'b0;
            if (drop_cnt < 255) drop_cnt++;
          end else begin
            check("fetch_addr", 32'(s_addr), 32'(exp_pc));
            e.data = mem_img[exp_pc];
            e.pc = exp_pc;
            exp_q.push_back(e);
            exp_pc = exp_pc + 8'd1;
          end
        end
      end
    end
  end

  // Monitor: compares DUT output against the expected queue every cycle.
  initial begin : monitor
    bit prev_req = 1'b0;
    bit prev_ready = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    int prev_qsize = 0;
    ent_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (last_rst) begin
          check("rst_req", 32'(bus.mem_req), 32'd0);
          check("rst_valid", 32'(instr_valid), 32'd0);
          check("rst_addr", 32'(bus.mem_addr), 32'd0);
        end
        check("tied_zero", 32'({bus.mem_we, bus.mem_data_out}), 32'd0);
        check("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0 && instr_valid === 1'b1)
          check("head", 32'({instr, instr_pc}), 32'({exp_q[0].data, exp_q[0].pc}));
        if (!last_rst && prev_req && bus.mem_req === 1'b1)
          check("addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
        if (!last_rst && !prev_req && bus.mem_req === 1'b1)
          check("issue_legal", 32'(prev_qsize < DEPTH && !prev_ready), 32'd1);
`ifdef FETCH_DISCARD_CNT_EN
        check("discard_cnt", 32'(discard_cnt), 32'(drop_cnt));
`endif
      end
      prev_qsize = exp_q.size();
      prev_req = (bus.mem_req === 1'b1);
      prev_ready = (bus.mem_ready === 1'b1);
      prev_addr = bus.mem_addr;
      if (armed && rst === 1'b0 && bus.mem_req === 1'b1 && bus.mem_ready === 1'b1) begin
        n_grants++;
        last_grant_addr = bus.mem_addr;
      end
      if (armed && rst === 1'b0 && redirect === 1'b0 && instr_ack === 1'b1 &&
          instr_valid === 1'b1 && exp_q.size() != 0) begin
        e.data = instr;
        e.pc = instr_pc;
        log_q.push_back(e);
        $display("pop pc=0x%02h instr=0x%02h", instr_pc, instr);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    case (ack_mode)
      0: instr_ack = 1'b0;
      1: instr_ack = 1'b1;
      default: instr_ack = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic rst_on();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic rst_off();
    rst = 1'b0;
    n_grants = 0;
    log_q.delete();
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
  endtask

  task automatic wait_log(input int n, input int bound, input string name);
    int k = 0;
    while (log_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    check(name, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input logic [7:0] a, input int bound, input string name);
    int k = 0;
    while (!(bus.mem_req === 1'b1 && bus.mem_addr === a) && k < bound) begin
      tick();
      k++;
    end
    check(name, 32'(k < bound), 32'd1);
  endtask

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin : stimulus
    logic [7:0] lin [6];
    int k;
    lin = '{8'h2B, 8'h2B, 8'h3E, 8'h2D, 8'h5B, 8'h5D};
    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; instr_ack = 1'b0;

    // Linear fetch with an always-ready consumer.
    rst_on();
    randomize_mem();
    for (int i = 0; i < 6; i++) mem_img[i] = lin[i];
    ack_mode = 1;
    rst_off();
    wait_log(6, 300, "lin_wait");
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        check("lin_pc", 32'(log_q[i].pc), 32'(i));
        check("lin_data", 32'(log_q[i].data), 32'(lin[i]));
      end
    end

    // Back-pressure: no acks, FIFO fills, then one ack frees one slot.
    rst_on();
    ack_mode = 0;
    rst_off();
    repeat (40) tick();
    check("bp_grants", 32'(n_grants), 32'd4);
    check("bp_req_idle", 32'(bus.mem_req), 32'd0);
    ack_mode = 1;
    tick();
    ack_mode = 0;
    repeat (30) tick();
    check("bp_grants_after_ack", 32'(n_grants), 32'd5);
    check("bp_last_addr", 32'(last_grant_addr), 32'h04);

    // Redirect while the fetch of address 2 is waiting for the arbiter.
    rst_on();
    arb_fixed = 5;
    ack_mode = 1;
    rst_off();
    wait_req(8'h02, 100, "redir_req2");
    redirect = 1'b1;
    redirect_pc = 8'h40;
    tick();
    log_q.delete();
    wait_log(2, 200, "redir_wait");
    if (log_q.size() >= 2) begin
      check("redir_pc0", 32'(log_q[0].pc), 32'h40);
      check("redir_data0", 32'(log_q[0].data), 32'(mem_img[8'h40]));
      check("redir_pc1", 32'(log_q[1].pc), 32'h41);
    end
`ifdef FETCH_DISCARD_CNT_EN
    check("redir_discard_cnt", 32'(discard_cnt), 32'd1);
`endif
    arb_fixed = -1;

    // Redirect coinciding with ready and ack while two entries are queued.
    rst_on();
    ack_mode = 0;
    arb_fixed = 0;
    rst_off();
    for (k = 0; k < 100; k++) begin
      tick();
      #2;
      if (n_grants == 2 && bus.mem_req === 1'b1 && bus.mem_ready === 1'b1) break;
    end
    check("coinc_setup", 32'(k < 100), 32'd1);
    redirect = 1'b1;
    redirect_pc = 8'h80;
    instr_ack = 1'b1;
    tick();
    check("coinc_flush", 32'(instr_valid), 32'd0);
`ifdef FETCH_DISCARD_CNT_EN
    check("coinc_discard_cnt", 32'(discard_cnt), 32'd1);
`endif
    ack_mode = 1;
    wait_log(1, 100, "coinc_wait");
    if (log_q.size() >= 1) begin
      check("coinc_pc", 32'(log_q[0].pc), 32'h80);
      check("coinc_data", 32'(log_q[0].data), 32'(mem_img[8'h80]));
    end
    arb_fixed = -1;

    // PC wrap from 0xFF to 0x00.
    rst_on();
    randomize_mem();
    mem_img[8'hFF] = 8'h11;
    mem_img[8'h00] = 8'h22;
    ack_mode = 1;
    rst_off();
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 8'hFF;
    tick();
    log_q.delete();
    wait_log(2, 200, "wrap_wait");
    if (log_q.size() >= 2) begin
      check("wrap_pc0", 32'(log_q[0].pc), 32'hFF);
      check("wrap_data0", 32'(log_q[0].data), 32'h11);
      check("wrap_pc1", 32'(log_q[1].pc), 32'h00);
      check("wrap_data1", 32'(log_q[1].data), 32'h22);
    end

    // Reset while a request is outstanding.
    rst_on();
    randomize_mem();
    ack_mode = 1;
    arb_fixed = 4;
    rst_off();
    wait_req(8'h03, 200, "rreq_wait_req");
    rst = 1'b1;
    tick();
    check("rreq_req", 32'(bus.mem_req), 32'd0);
    check("rreq_valid", 32'(instr_valid), 32'd0);
    rst_off();
    arb_fixed = -1;
    wait_log(1, 100, "rreq_wait");
    if (log_q.size() >= 1) begin
      check("rreq_pc", 32'(log_q[0].pc), 32'h00);
      check("rreq_data", 32'(log_q[0].data), 32'(mem_img[8'h00]));
    end

    // Randomized acks, redirects, arbiter latency and occasional resets.
    rst_on();
    randomize_mem();
    ack_mode = 2;
    rst_off();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        redirect = 1'b1;
        redirect_pc = 8'($urandom);
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (5) tick();
    check("rand_progress", 32'(log_q.size() > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "time limit");
  end

endmodule
